// File: rtl/deco_scheduler.sv
// Sequences hours/minutes/seconds through a shared two-digit decoder and
// commits the resulting BCD triple atomically, flagging out-of-range fields.
module deco_scheduler #(
  parameter int unsigned DECO_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       auto_scan,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [5:0] deco_number,
  input  logic [3:0] deco_decimals,
  input  logic [3:0] deco_units,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned FW = 6;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    fld_q, fld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] hr_snap_q, hr_snap_d, min_snap_q, min_snap_d, sec_snap_q, sec_snap_d;
  logic [FW-1:0] num_q, num_d;
  logic [BW-1:0] sh_hr_q, sh_hr_d, sh_min_q, sh_min_d;
  logic [BW-1:0] hr_bcd_q, hr_bcd_d, min_bcd_q, min_bcd_d, sec_bcd_q, sec_bcd_d;
  logic          pend_q, pend_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic          fld_bad;
  logic [BW-1:0] cap_val;

  // Range check of the field currently being decoded; bad fields read as 99.
  always_comb begin
    unique case (fld_q)
      2'd0:    fld_bad = hr_snap_q > FW'(23);
      2'd1:    fld_bad = min_snap_q > FW'(59);
      default: fld_bad = sec_snap_q > FW'(59);
    endcase
    cap_val = fld_bad ? BW'(8'h99) : {deco_decimals, deco_units};
  end

  always_comb begin
    state_d    = state_q;
    fld_d      = fld_q;
    cnt_d      = cnt_q;
    hr_snap_d  = hr_snap_q;
    min_snap_d = min_snap_q;
    sec_snap_d = sec_snap_q;
    num_d      = num_q;
    sh_hr_d    = sh_hr_q;
    sh_min_d   = sh_min_q;
    hr_bcd_d   = hr_bcd_q;
    min_bcd_d  = min_bcd_q;
    sec_bcd_d  = sec_bcd_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (start || auto_scan) begin
          hr_snap_d  = hours;
          min_snap_d = minutes;
          sec_snap_d = seconds;
          num_d      = hours;
          fld_d      = 2'd0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == CW'(DECO_LAT - 1)) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPTURE: begin
        pend_d = pend_q | fld_bad;
        if (fld_q == 2'd0) begin
          sh_hr_d = cap_val;
          num_d   = min_snap_q;
          fld_d   = 2'd1;
          state_d = ISSUE;
        end else if (fld_q == 2'd1) begin
          sh_min_d = cap_val;
          num_d    = sec_snap_q;
          fld_d    = 2'd2;
          state_d  = ISSUE;
        end else begin
          // Seconds bypass their shadow so the whole triple lands on one edge.
          hr_bcd_d  = sh_hr_q;
          min_bcd_d = sh_min_q;
          sec_bcd_d = cap_val;
          err_d     = pend_q | fld_bad;
          pend_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = COMMIT;
        end
      end
      COMMIT: begin
        busy_d  = 1'b0;
        fld_d   = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fld_q      <= '0;
      cnt_q      <= '0;
      hr_snap_q  <= '0;
      min_snap_q <= '0;
      sec_snap_q <= '0;
      num_q      <= '0;
      sh_hr_q    <= '0;
      sh_min_q   <= '0;
      hr_bcd_q   <= '0;
      min_bcd_q  <= '0;
      sec_bcd_q  <= '0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fld_q      <= fld_d;
      cnt_q      <= cnt_d;
      hr_snap_q  <= hr_snap_d;
      min_snap_q <= min_snap_d;
      sec_snap_q <= sec_snap_d;
      num_q      <= num_d;
      sh_hr_q    <= sh_hr_d;
      sh_min_q   <= sh_min_d;
      hr_bcd_q   <= hr_bcd_d;
      min_bcd_q  <= min_bcd_d;
      sec_bcd_q  <= sec_bcd_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign deco_number = num_q;
  assign hr_bcd      = hr_bcd_q;
  assign min_bcd     = min_bcd_q;
  assign sec_bcd     = sec_bcd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_deco_scheduler.sv
// Bench for deco_scheduler: behavioural pipelined decoders at latency 1 and 3,
// scoreboard of expected committed triples.
module tb_deco_scheduler;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, auto_scan = 1'b0, start3 = 1'b0, auto3 = 1'b0;
  logic [5:0] hours = '0, minutes = '0, seconds = '0;
  logic [5:0] num1, num3;
  logic [3:0] dec1_t, dec1_u, dec3_t, dec3_u;
  logic [7:0] hr1, mn1, sc1, hr3, mn3, sc3;
  logic       busy1, done1, err1, busy3, done3, err3;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] dec(input logic [5:0] v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_bcd(input logic [5:0] v, input int lim);
    return (int'(v) > lim) ? 8'h99 : dec(v);
  endfunction

  function automatic exp_t mk_exp(input logic [5:0] h, m, s);
    exp_t x;
    x.h = exp_bcd(h, 23);
    x.m = exp_bcd(m, 59);
    x.s = exp_bcd(s, 59);
    x.e = (h > 6'd23) || (m > 6'd59) || (s > 6'd59);
    return x;
  endfunction

  // Decoder models: result valid DECO_LAT edges after the operand settles.
  logic [7:0] p1;
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    p1    <= dec(num1);
    p3[0] <= dec(num3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {dec1_t, dec1_u} = p1;
  assign {dec3_t, dec3_u} = p3[2];

  deco_scheduler #(.DECO_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_scan(auto_scan),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .deco_number(num1), .deco_decimals(dec1_t), .deco_units(dec1_u),
    .hr_bcd(hr1), .min_bcd(mn1), .sec_bcd(sc1),
    .busy(busy1), .done(done1), .err(err1)
  );

  deco_scheduler #(.DECO_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .auto_scan(auto3),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .deco_number(num3), .deco_decimals(dec3_t), .deco_units(dec3_u),
    .hr_bcd(hr3), .min_bcd(mn3), .sec_bcd(sc3),
    .busy(busy3), .done(done3), .err(err3)
  );

  // Starts one scan on dut, pushes its expectation, waits (bounded) for done.
  task automatic run_scan(input logic [5:0] h, m, s, output int lat, output bit stable);
    logic [24:0] prev;
    @(negedge clk);
    hours = h; minutes = m; seconds = s; start = 1'b1;
    prev = {hr1, mn1, sc1, err1};
    sb.push_back(mk_exp(h, m, s));
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    stable = 1'b1;
    while (!done1 && lat < 60) begin
      if ({hr1, mn1, sc1, err1} !== prev) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hr1, mn1, sc1, busy1, done1, err1, num1} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_held: got %h want 0", {hr1, mn1, sc1, busy1, done1, err1, num1});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy1, done1, busy3, done3} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy/done %b want 0000", {busy1, done1, busy3, done3});
    end
  endtask

  task automatic test_basic();
    int lat; bit stable; exp_t x;
    run_scan(6'd12, 6'd34, 6'd56, lat, stable);
    x = sb.pop_front();
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("FAIL basic_latency: got %0d want 7", lat); end
    n_checks++;
    if (hr1 !== x.h) begin n_fail++; $display("FAIL basic_hr: got %h want %h", hr1, x.h); end
    n_checks++;
    if (mn1 !== x.m) begin n_fail++; $display("FAIL basic_min: got %h want %h", mn1, x.m); end
    n_checks++;
    if (sc1 !== x.s) begin n_fail++; $display("FAIL basic_sec: got %h want %h", sc1, x.s); end
    n_checks++;
    if (err1 !== x.e) begin n_fail++; $display("FAIL basic_err: got %b want %b", err1, x.e); end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL basic_atomic: outputs changed before done, want stable"); end
    @(negedge clk);
    n_checks++;
    if ({done1, busy1} !== 2'b00) begin n_fail++; $display("FAIL basic_pulse: done/busy %b want 00", {done1, busy1}); end
  endtask

  task automatic test_range();
    int lat; bit stable; exp_t x;
    run_scan(6'd0, 6'd60, 6'd59, lat, stable);
    x = sb.pop_front();
    n_checks++;
    if ({hr1, mn1, sc1, err1} !== x) begin
      n_fail++;
      $display("FAIL range_bad: got %h/%h/%h err %b want %h/%h/%h err %b", hr1, mn1, sc1, err1, x.h, x.m, x.s, x.e);
    end
    run_scan(6'd0, 6'd0, 6'd0, lat, stable);
    x = sb.pop_front();
    n_checks++;
    if ({hr1, mn1, sc1, err1} !== x) begin
      n_fail++;
      $display("FAIL range_clear: got %h/%h/%h err %b want %h/%h/%h err %b", hr1, mn1, sc1, err1, x.h, x.m, x.s, x.e);
    end
  endtask

  task automatic test_busy_ignore();
    int dones = 0; exp_t x; logic [24:0] got = '0;
    @(negedge clk);
    hours = 6'd7; minutes = 6'd45; seconds = 6'd3; start = 1'b1;
    sb.push_back(mk_exp(6'd7, 6'd45, 6'd3));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    minutes = 6'd11; hours = 6'd22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done1) begin dones++; got = {hr1, mn1, sc1, err1}; end
      @(negedge clk);
    end
    x = sb.pop_front();
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL busy_ignore_count: got %0d dones want 1", dones); end
    n_checks++;
    if (got !== x) begin n_fail++; $display("FAIL busy_ignore_value: got %h want %h", got, x); end
  endtask

  task automatic test_auto();
    int t1 [3]; int t3 [3]; int c1 = 0; int c3 = 0; int badv = 0; exp_t x;
    for (int i = 0; i < 3; i++) begin t1[i] = 0; t3[i] = 0; end
    x = mk_exp(6'd23, 6'd59, 6'd59);
    @(negedge clk);
    hours = 6'd23; minutes = 6'd59; seconds = 6'd59;
    auto_scan = 1'b1; auto3 = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done1) begin
        if (c1 < 3) t1[c1] = cyc;
        c1++;
        if ({hr1, mn1, sc1, err1} !== x) badv++;
      end
      if (done3) begin
        if (c3 < 3) t3[c3] = cyc;
        c3++;
        if ({hr3, mn3, sc3, err3} !== x) badv++;
      end
    end
    auto_scan = 1'b0; auto3 = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (t1[1] - t1[0] !== 8 || t1[2] - t1[1] !== 8) begin
      n_fail++; $display("FAIL auto_period_lat1: got %0d,%0d want 8,8", t1[1] - t1[0], t1[2] - t1[1]);
    end
    n_checks++;
    if (t3[1] - t3[0] !== 14 || t3[2] - t3[1] !== 14) begin
      n_fail++; $display("FAIL auto_period_lat3: got %0d,%0d want 14,14", t3[1] - t3[0], t3[2] - t3[1]);
    end
    n_checks++;
    if (badv !== 0 || c1 < 3 || c3 < 3) begin
      n_fail++; $display("FAIL auto_values: got %0d bad, dones %0d/%0d want 0 bad, >=3 each", badv, c1, c3);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0; int lat; bit stable; exp_t x;
    @(negedge clk);
    hours = 6'd12; minutes = 6'd34; seconds = 6'd56; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({hr1, mn1, sc1, busy1, done1, err1, num1} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 0", {hr1, mn1, sc1, busy1, done1, err1, num1});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1 || busy1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL reset_abort: got %0d active cycles want 0", dones); end
    run_scan(6'd5, 6'd6, 6'd7, lat, stable);
    x = sb.pop_front();
    n_checks++;
    if ({hr1, mn1, sc1, err1} !== x || lat !== 7) begin
      n_fail++; $display("FAIL reset_recover: got %h lat %0d want %h lat 7", {hr1, mn1, sc1, err1}, lat, x);
    end
  endtask

  task automatic test_boundary();
    logic [5:0] hl [5];
    logic [5:0] fl [4];
    int lat; bit stable; exp_t x;
    hl = '{6'd0, 6'd9, 6'd10, 6'd23, 6'd24};
    fl = '{6'd0, 6'd9, 6'd10, 6'd59};
    for (int i = 0; i < 5; i++) begin
      run_scan(hl[i], fl[i % 4], fl[(i + 1) % 4], lat, stable);
      x = sb.pop_front();
      n_checks++;
      if ({hr1, mn1, sc1, err1} !== x || lat !== 7 || !stable) begin
        n_fail++;
        $display("FAIL boundary_%0d: got %h/%h/%h err %b lat %0d want %h/%h/%h err %b lat 7",
                 i, hr1, mn1, sc1, err1, lat, x.h, x.m, x.s, x.e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_busy_ignore();
    test_auto();
    test_reset_mid();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
